// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_mult core between NUM_REQ requesters.
// Optional activity counters are compiled in with FP_MULT_ARB_STATS_EN.
module fp_mult_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned MULTPLIER_LATENCY = 5,
  parameter int unsigned TAG_W             = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_dataa,
  input  logic [NUM_REQ*32-1:0]  req_datab,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_nan,
  output logic [31:0]            mul_dataa,
  output logic [31:0]            mul_datab,
  input  logic [31:0]            mul_result,
  input  logic                   mul_nan,
  output logic                   busy
`ifdef FP_MULT_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issues,
  output logic [31:0]            stat_stalls
`endif
);

  // Stage 0 mirrors the operand register; the remaining stages follow the core
  // from its input capture to its result register, giving grant-to-response of
  // MULTPLIER_LATENCY+2 enabled cycles.
  localparam int unsigned STAGES = MULTPLIER_LATENCY + 2;
  localparam int unsigned LAST   = STAGES - 1;

  logic [TAG_W-1:0]     rr_ptr;
  logic [2*NUM_REQ-1:0] rot;
  logic                 grant_any;
  logic [TAG_W:0]       grant_sum;
  logic [TAG_W-1:0]     grant_id;
  logic [31:0]          sel_a;
  logic [31:0]          sel_b;

  logic                 tag_v  [STAGES];
  logic [TAG_W-1:0]     tag_id [STAGES];

  // Rotate the request vector so the search always starts at rr_ptr.
  always_comb begin
    rot       = {req_valid, req_valid} >> rr_ptr;
    grant_any = 1'b0;
    grant_sum = '0;
    if (clk_en && !reset) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!grant_any && rot[j]) begin
          grant_any = 1'b1;
          grant_sum = {1'b0, rr_ptr} + (TAG_W+1)'(j);
        end
      end
    end
    if (grant_sum >= (TAG_W+1)'(NUM_REQ))
      grant_sum = grant_sum - (TAG_W+1)'(NUM_REQ);
    grant_id = grant_sum[TAG_W-1:0];
  end

  always_comb begin
    req_grant = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_any && grant_id == TAG_W'(r)) begin
        req_grant[r] = 1'b1;
        sel_a        = req_dataa[32*r +: 32];
        sel_b        = req_datab[32*r +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      mul_dataa <= '0;
      mul_datab <= '0;
    end else if (grant_any) begin
      rr_ptr    <= (grant_id == TAG_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      mul_dataa <= sel_a;
      mul_datab <= sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else if (clk_en) begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int unsigned s = 1; s < STAGES; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_nan   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (clk_en && tag_v[LAST]) begin
        rsp_valid <= NUM_REQ'(1) << tag_id[LAST];
        rsp_data  <= mul_result;
        rsp_nan   <= mul_nan;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned s = 0; s < STAGES; s++)
      busy = busy | tag_v[s];
  end

`ifdef FP_MULT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issues <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant_any && stat_issues != '1)
        stat_issues <= stat_issues + 32'd1;
      if (clk_en && (|(req_valid & ~req_grant)) && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
